// File: rtl/sm_hazard_sb_if.sv
// Purpose: pipeline-hazard bundle between the D/E/M/W stage datapath and the hazard/scoreboard unit.
// Latency: n/a (wires only); stall/forward outputs are combinational, pending/outCnt are registered in the unit.
// Backpressure: the unit throttles issue through stall_n_F/stall_n_D/flush_n_E; the datapath must honour them.
// Ports: D-stage sources/dest/issue, E/M/W write-back tags, long-unit completion (lwb_*),
//        and unit outputs fwdA_E/fwdB_E, stall/flush strobes, pending bitmap, outCnt, drainBusy, sbErr.
interface sm_hazard_sb_if #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CW   = 3
);
    // decode stage
    logic          issue_D;
    logic [AW-1:0] rs_D;
    logic [AW-1:0] rt_D;
    logic          rsUse_D;
    logic          rtUse_D;
    logic [AW-1:0] rd_D;
    logic          regWr_D;
    logic          longWr_D;
    logic          sync_D;
    // execute / memory / write-back stages
    logic [AW-1:0] rs_E;
    logic [AW-1:0] rt_E;
    logic [AW-1:0] writeReg_E;
    logic          regWrite_E;
    logic          memToReg_E;
    logic [AW-1:0] writeReg_M;
    logic          regWrite_M;
    logic [AW-1:0] writeReg_W;
    logic          regWrite_W;
    // long-latency unit completion
    logic          lwb_valid;
    logic [AW-1:0] lwb_reg;
    // unit outputs
    logic [1:0]      fwdA_E;
    logic [1:0]      fwdB_E;
    logic            stall_n_F;
    logic            stall_n_D;
    logic            flush_n_E;
    logic [NREG-1:0] pending;
    logic [CW-1:0]   outCnt;
    logic            drainBusy;
    logic            sbErr;

    modport master (
        output issue_D, rs_D, rt_D, rsUse_D, rtUse_D, rd_D, regWr_D, longWr_D, sync_D,
        output rs_E, rt_E, writeReg_E, regWrite_E, memToReg_E,
        output writeReg_M, regWrite_M, writeReg_W, regWrite_W,
        output lwb_valid, lwb_reg,
        input  fwdA_E, fwdB_E, stall_n_F, stall_n_D, flush_n_E,
        input  pending, outCnt, drainBusy, sbErr
    );

    modport slave (
        input  issue_D, rs_D, rt_D, rsUse_D, rtUse_D, rd_D, regWr_D, longWr_D, sync_D,
        input  rs_E, rt_E, writeReg_E, regWrite_E, memToReg_E,
        input  writeReg_M, regWrite_M, writeReg_W, regWrite_W,
        input  lwb_valid, lwb_reg,
        output fwdA_E, fwdB_E, stall_n_F, stall_n_D, flush_n_E,
        output pending, outCnt, drainBusy, sbErr
    );
endinterface

// File: rtl/sm_hazard_sb.sv
// Purpose: hazard detection, E-stage forwarding and long-latency write scoreboard with sync drain FSM.
// Latency: forward/stall combinational; pending/outCnt/FSM/sbErr update one clock after issue/completion.
// Backpressure: any hazard on a valid D instruction stalls F/D and flushes E (all active-low strobes).
// Ports: clk, rst_n (synchronous, active-low), hz (sm_hazard_sb_if.slave) carrying all pipeline tags.
// Interface parameters NREG/AW/CW must match the module parameters of the same name.
module sm_hazard_sb #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int NPEND = 4,
    parameter int CW    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    sm_hazard_sb_if.slave hz
);
    localparam logic [1:0]    HZ_FW_NONE = 2'b00;
    localparam logic [1:0]    HZ_FW_ME   = 2'b10;
    localparam logic [1:0]    HZ_FW_WE   = 2'b01;
    localparam logic [AW-1:0] REG_ZERO   = '0;
    localparam logic [CW-1:0] CNT_ZERO   = '0;
    localparam logic [CW-1:0] CNT_FULL   = CW'(NPEND);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state, stateNext;
    logic [NREG-1:0] pendQ, pendNext;
    logic [CW-1:0]   outCntQ, outCntNext;
    logic            sbErrQ, sbErrNext;

    logic loadUse, rawHaz, wawHaz, structHaz, drainHaz, stall;
    logic issueLong, doneOk, lwbBad;

    // regWrite_E is part of the bundle but the load-use check keys only on memToReg_E.
    logic unusedSigs;
    assign unusedSigs = hz.regWrite_E;

    // ---------------- forwarding ----------------
    function automatic logic [1:0] fwdSel(
        input logic [AW-1:0] src,
        input logic [AW-1:0] regM, input logic wrM,
        input logic [AW-1:0] regW, input logic wrW
    );
        if (src == REG_ZERO)            return HZ_FW_NONE;
        else if (src == regM && wrM)    return HZ_FW_ME;
        else if (src == regW && wrW)    return HZ_FW_WE;
        else                            return HZ_FW_NONE;
    endfunction

    assign hz.fwdA_E = fwdSel(hz.rs_E, hz.writeReg_M, hz.regWrite_M, hz.writeReg_W, hz.regWrite_W);
    assign hz.fwdB_E = fwdSel(hz.rt_E, hz.writeReg_M, hz.regWrite_M, hz.writeReg_W, hz.regWrite_W);

    // ---------------- stall causes ----------------
    always_comb begin
        loadUse = hz.memToReg_E && (hz.writeReg_E != REG_ZERO) &&
                  ((hz.rsUse_D && hz.rs_D == hz.writeReg_E) ||
                   (hz.rtUse_D && hz.rt_D == hz.writeReg_E));
        // Reads the registered bitmap only: a completion in this cycle does not unblock until next cycle.
        rawHaz    = (hz.rsUse_D && pendQ[hz.rs_D]) || (hz.rtUse_D && pendQ[hz.rt_D]);
        wawHaz    = (hz.regWr_D || hz.longWr_D) && pendQ[hz.rd_D];
        // Registered count only, so a same-cycle completion never frees the slot early.
        structHaz = hz.longWr_D && (outCntQ == CNT_FULL);
        drainHaz  = (state == DRAIN) ||
                    (state == IDLE && hz.sync_D && outCntQ != CNT_ZERO);
        stall     = hz.issue_D && (loadUse || rawHaz || wawHaz || structHaz || drainHaz);
    end

    assign hz.stall_n_F = ~stall;
    assign hz.stall_n_D = ~stall;
    assign hz.flush_n_E = ~stall;

    // ---------------- scoreboard next state ----------------
    always_comb begin
        pendNext   = pendQ;
        outCntNext = outCntQ;
        sbErrNext  = sbErrQ;
        issueLong  = hz.issue_D && hz.longWr_D && !stall;
        // A completion with nothing outstanding is an error and must not underflow the count.
        doneOk     = hz.lwb_valid && (outCntQ != CNT_ZERO);
        lwbBad     = hz.lwb_valid &&
                     ((outCntQ == CNT_ZERO) || (hz.lwb_reg != REG_ZERO && !pendQ[hz.lwb_reg]));

        if (hz.lwb_valid)
            pendNext[hz.lwb_reg] = 1'b0;
        // Set after clear: issue to the register being completed leaves it pending.
        if (issueLong && hz.rd_D != REG_ZERO)
            pendNext[hz.rd_D] = 1'b1;
        pendNext[0] = 1'b0;

        case ({issueLong, doneOk})
            2'b10:   outCntNext = outCntQ + 1'b1;
            2'b01:   outCntNext = outCntQ - 1'b1;
            default: outCntNext = outCntQ;
        endcase

        if (lwbBad)
            sbErrNext = 1'b1;
    end

    // ---------------- drain FSM ----------------
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (hz.issue_D && hz.sync_D && outCntQ != CNT_ZERO) stateNext = DRAIN;
            DRAIN:   if (outCntQ == CNT_ZERO) stateNext = RELEASE;
            RELEASE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pendQ   <= '0;
            outCntQ <= '0;
            sbErrQ  <= 1'b0;
        end else begin
            state   <= stateNext;
            pendQ   <= pendNext;
            outCntQ <= outCntNext;
            sbErrQ  <= sbErrNext;
        end
    end

    assign hz.pending   = pendQ;
    assign hz.outCnt    = outCntQ;
    assign hz.drainBusy = (state == DRAIN);
    assign hz.sbErr     = sbErrQ;
endmodule

// File: doc/sm_hazard_sb.md
SM_HAZARD_SB -- requirements
Module: sm_hazard_sb

Interface
REQ-001 Parameter NREG, default 32, number of architectural registers.
REQ-002 Parameter AW, default 5, register address width (2^AW >= NREG).
REQ-003 Parameter NPEND, default 4, maximum outstanding long-latency writes.
REQ-004 Parameter CW, default 3, outstanding-counter width (2^CW > NPEND).
REQ-005 clk  in  1  clock; single clock domain, all state on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 issue_D  in  1  valid instruction present in D.
REQ-008 rs_D, rt_D  in  AW each  D source registers; rsUse_D, rtUse_D in 1 each, source actually read.
REQ-009 rd_D  in  AW  D destination; regWr_D in 1 short-pipe write; longWr_D in 1 long-latency write.
REQ-010 sync_D  in  1  D instruction requires empty scoreboard before issue.
REQ-011 rs_E, rt_E, writeReg_E  in  AW each; regWrite_E, memToReg_E in 1 each.
REQ-012 writeReg_M, writeReg_W  in  AW each; regWrite_M, regWrite_W in 1 each.
REQ-013 lwb_valid  in  1, lwb_reg  in  AW  long-latency unit completion/write-back.
REQ-014 fwdA_E, fwdB_E  out  2 each  E forward select, HZ_FW_NONE/HZ_FW_ME/HZ_FW_WE encodings.
REQ-015 stall_n_F, stall_n_D, flush_n_E  out  1 each  active-low stall/flush.
REQ-016 pending  out  NREG  registered per-register pending-write bitmap.
REQ-017 outCnt  out  CW  registered outstanding long-write count.
REQ-018 drainBusy  out  1 (state==DRAIN); sbErr  out  1 sticky completion-error flag.

Function
REQ-019 fwdA_E: NONE if rs_E==0; else ME if rs_E==writeReg_M && regWrite_M; else WE if rs_E==writeReg_W && regWrite_W; else NONE. fwdB_E identical on rt_E; combinational.
REQ-020 Load-use stall: memToReg_E && writeReg_E!=0 && ((rsUse_D && rs_D==writeReg_E) || (rtUse_D && rt_D==writeReg_E)).
REQ-021 RAW stall: (rsUse_D && pending[rs_D]) || (rtUse_D && pending[rt_D]); no same-cycle bypass from lwb_valid.
REQ-022 WAW stall: (regWr_D || longWr_D) && pending[rd_D].
REQ-023 Structural stall: longWr_D && outCnt==NPEND; same-cycle completion does not free the slot.
REQ-024 Drain stall: per FSM (REQ-028..030).
REQ-025 stall = issue_D && OR(REQ-020..024); stall_n_F = stall_n_D = flush_n_E = ~stall.
REQ-026 Issue of long write (issue_D && longWr_D && !stall): next cycle pending[rd_D]=1 (rd_D==0: pending untouched), outCnt+1.
REQ-027 Completion (lwb_valid): pending[lwb_reg] cleared, outCnt-1; same-cycle issue+completion: outCnt unchanged; same register: set wins; pending[0] always 0.
REQ-028 FSM IDLE: issue_D && sync_D && outCnt!=0 -> DRAIN, stall asserted this cycle; outCnt==0 -> no drain stall, stay IDLE.
REQ-029 FSM DRAIN: drain stall asserted; registered outCnt==0 -> RELEASE.
REQ-030 FSM RELEASE: no drain stall for exactly one cycle, -> IDLE; other stall causes still apply.
REQ-031 lwb_valid while outCnt==0, or lwb_reg not pending and !=0: sbErr set, outCnt saturates at 0, sticky until reset.
REQ-032 outCnt never exceeds NPEND; issue blocked by REQ-023.

Reset
REQ-033 rst_n low at a clock edge: pending=0, outCnt=0, FSM=IDLE, sbErr=0, regardless of in-flight activity; combinational outputs follow inputs.

Verification
REQ-034 Long write to r5 issued, next D reads r5 (rsUse_D=1) -> stall_n_D=0 until cycle after lwb_valid with lwb_reg=5, pending[5] then 0, outCnt 1->0.
REQ-035 memToReg_E=1, writeReg_E=3, rt_D=3, rtUse_D=1 -> stall_n_F=stall_n_D=flush_n_E=0 one cycle; writeReg_E=0 case -> no stall.
REQ-036 NPEND=4 long writes to r1..r4 outstanding, fifth longWr_D -> stall; lwb_valid r1 same cycle -> still stall, issues next cycle, outCnt=4.
REQ-037 outCnt=2, sync_D issued -> DRAIN, drainBusy=1, stall until both completions, one RELEASE cycle no stall, back to IDLE.
REQ-038 lwb_valid with outCnt=0 -> sbErr=1, outCnt=0; rst_n=0 mid-DRAIN -> IDLE, pending=0, sbErr=0.
REQ-039 rs_E=7 matches writeReg_M and writeReg_W, both regWrite -> fwdA_E=HZ_FW_ME; rs_E=0 -> HZ_FW_NONE.
